bram_dual_port_arbiter: RTL and testbench
=========================================

// Module: bram_dual_port_arbiter
//
// PURPOSE
// - Shares a true dual-port byte-enable block RAM (1-cycle read latency) between NUM_REQ requesters.
// - Each cycle grants up to two requests in round-robin order: first to port A, second to port B.
// - Never issues a same-address port A/B pair where either side writes; the RAM would return X for that pair.
// - Routes read data back to the issuing requester.
// - Sits between client logic (CPU/DMA/accelerator lanes) and the RAM instance.
//
// PARAMETERS
// - NUM_REQ    4              number of requesters (2..16)
// - ADDR_WIDTH 10             RAM address width
// - DATA_WIDTH 32             RAM data width (multiple of 8)
// - BE_WIDTH   DATA_WIDTH/8   byte-enable width
// - ID_WIDTH   $clog2(NUM_REQ)   requester index width (derived)
//
// PORTS
// - CLK        in   1                     clock, all logic on posedge
// - RESET      in   1                     synchronous, active-high reset
// - REQ_VALID  in   NUM_REQ               request valid, one bit per requester
// - REQ_READY  out  NUM_REQ               request accepted this cycle (grant)
// - REQ_WE     in   NUM_REQ               1 = write, 0 = read
// - REQ_ADDR   in   NUM_REQ*ADDR_WIDTH    address; requester i at [i*AW +: AW]
// - REQ_DATA   in   NUM_REQ*DATA_WIDTH    write data
// - REQ_BE     in   NUM_REQ*BE_WIDTH      byte enables (writes only)
// - RESP_VALID out  NUM_REQ               response pulse, one bit per requester
// - RESP_DATA  out  NUM_REQ*DATA_WIDTH    read data for requester i
// - DI_A, ADDR_A, WE_A, RE_A, BE_A   out  port A drive to RAM
// - DO_A       in   DATA_WIDTH            port A read data from RAM
// - DI_B, ADDR_B, WE_B, RE_B, BE_B   out  port B drive to RAM
// - DO_B       in   DATA_WIDTH            port B read data from RAM
//
// BEHAVIOUR
// Arbitration (combinational from REQ_* and rr_ptr):
// - Scan from rr_ptr upward, modulo NUM_REQ.
//   - First valid requester -> gA.
//   - Next valid requester -> gB candidate.
// - Candidate dropped if ADDR equals gA's ADDR and (WE[gA] | WE[cand]).
//   - No further candidate is searched that cycle.
// - Two reads of the same address are both granted.
// - A requester never holds both ports.
// - REQ_READY[i] = 1 iff i is granted. Handshake completes when REQ_VALID & REQ_READY.
//   - Requesters hold all REQ_* fields stable until READY.
// - RAM drive for each port p with a grant:
//   - WE_p = REQ_WE[g]; RE_p = ~REQ_WE[g].
//   - ADDR_p, DI_p, BE_p = requester g's fields.
// - RAM drive for a port without a grant:
//   - WE_p = RE_p = 0; ADDR, DI, BE = 0.
// - rr_ptr register:
//   - After a cycle with grants, rr_ptr <= (last granted index + 1) mod NUM_REQ.
//   - Last granted = gB if B granted, else gA.
//   - Unchanged when no grant.
// Response path (1 stage):
// - Per port, register rsp_v_p and rsp_id_p.
// - rsp_v_p <= port p granted a read this cycle.
// - Next cycle: RESP_VALID[rsp_id_p] = 1 and RESP_DATA[rsp_id_p] = DO_p.
//   - Read-to-response latency is exactly 1 cycle after the READY cycle.
// - No response backpressure; requesters must accept the pulse.
// - RESP_DATA lanes with no response are 0.
// - One requester may have new requests granted while its previous response is in flight.
// Reset:
// - While RESET is high, all grants are forced 0: REQ_READY=0, WE_*=RE_*=0.
// - Next state: rr_ptr=0, rsp_v_A=rsp_v_B=0.
//   - RESP_VALID=0 and RESP_DATA=0 from the following cycle.
// - A read granted in the cycle before RESET is asserted is dropped; no RESP_VALID.
// Boundaries:
// - Only one valid requester -> port A only, port B idle.
// - rr_ptr wraps from NUM_REQ-1 to 0.
// - A conflict-deferred requester is first in scan order next cycle, so no starvation.
//
// CONFIGURATION
// - Macro BRAM_ARB_WRITE_ACK_EN.
// - Defined:
//   - Granted writes also set rsp_v_p.
//   - Next cycle: RESP_VALID[id]=1 with RESP_DATA[id]=0.
//   - Every accepted request gets exactly one response.
// - Undefined:
//   - Writes produce no response.
//   - RESP_VALID only for reads.
//
// TESTING
// 1. After reset, REQ_VALID=4'b0001, WE=0, ADDR=5, RAM[5]=32'hCAFE0001
//    -> READY=0001, RE_A=1, ADDR_A=5; next cycle RESP_VALID=0001, RESP_DATA[0]=32'hCAFE0001.
// 2. REQ_VALID=4'b1111 held, all reads, distinct addresses, rr_ptr=0
//    -> grants {0,1}, {2,3}, {0,1}: two READY bits per cycle, pointer wraps.
// 3. Req1 write ADDR=7, req2 read ADDR=7, rr_ptr=0
//    -> cycle 1: only req1 granted on A, WE_B=RE_B=0.
//    -> cycle 2: req2 granted on A, reads the written value.
// 4. Req0 and req3 both read ADDR=9
//    -> both granted same cycle, A=req0, B=req3.
//    -> next cycle RESP_VALID=1001, both lanes = RAM[9].
// 5. Write BE=4'b0010 DATA=32'h0000AB00 to ADDR=3 holding 32'h11223344, then read ADDR=3
//    -> response 32'h1122AB44; with BRAM_ARB_WRITE_ACK_EN the write also pulses RESP_VALID with data 0.
// 6. Assert RESET the cycle after a read grant, with all REQ_VALID=1
//    -> READY=0, WE/RE=0 during reset, no RESP_VALID.
//    -> after release, first grant goes to req0 on port A.

Source files
------------

// File: rtl/bram_dual_port_arbiter.sv
// rtl/bram_dual_port_arbiter.sv - round-robin arbiter sharing a true dual-port BRAM between NUM_REQ requesters
// Optional write acknowledge responses: define BRAM_ARB_WRITE_ACK_EN.
module bram_dual_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [NUM_REQ-1:0]               REQ_VALID,
    output logic [NUM_REQ-1:0]               REQ_READY,
    input  logic [NUM_REQ-1:0]               REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_DATA,
    input  logic [NUM_REQ*BE_WIDTH-1:0]      REQ_BE,
    output logic [NUM_REQ-1:0]               RESP_VALID,
    output logic [NUM_REQ*DATA_WIDTH-1:0]    RESP_DATA,
    output logic [DATA_WIDTH-1:0]            DI_A,
    output logic [ADDR_WIDTH-1:0]            ADDR_A,
    output logic                             WE_A,
    output logic                             RE_A,
    output logic [BE_WIDTH-1:0]              BE_A,
    input  logic [DATA_WIDTH-1:0]            DO_A,
    output logic [DATA_WIDTH-1:0]            DI_B,
    output logic [ADDR_WIDTH-1:0]            ADDR_B,
    output logic                             WE_B,
    output logic                             RE_B,
    output logic [BE_WIDTH-1:0]              BE_B,
    input  logic [DATA_WIDTH-1:0]            DO_B
);

    localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);

    logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [BE_WIDTH-1:0]   be_arr   [NUM_REQ];

    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                rsp_v_a_q, rsp_v_a_d, rsp_v_b_q, rsp_v_b_d;
    logic [ID_WIDTH-1:0] rsp_id_a_q, rsp_id_a_d, rsp_id_b_q, rsp_id_b_d;
    logic [ID_WIDTH-1:0] g_a, g_b, idx;
    logic [ID_WIDTH:0]   idx_w;
    logic                gnt_a, gnt_b, scan_done;
    logic [DATA_WIDTH-1:0] rsp_data_a, rsp_data_b;

    function automatic logic [ID_WIDTH-1:0] inc_wrap(input logic [ID_WIDTH-1:0] g);
        logic [ID_WIDTH:0] s;
        s = {1'b0, g} + (ID_WIDTH + 1)'(1);
        if (s == NUM_REQ_W) s = '0;
        return s[ID_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            be_arr[i]   = REQ_BE[i*BE_WIDTH +: BE_WIDTH];
        end
    end

    // The scan stops at the second valid requester even if it is dropped for an address clash.
    always_comb begin
        gnt_a     = 1'b0;
        gnt_b     = 1'b0;
        g_a       = '0;
        g_b       = '0;
        scan_done = 1'b0;
        idx_w     = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(k);
            if (idx_w >= NUM_REQ_W) idx_w = idx_w - NUM_REQ_W;
            idx = idx_w[ID_WIDTH-1:0];
            if (REQ_VALID[idx] && !scan_done) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    g_a   = idx;
                end else begin
                    scan_done = 1'b1;
                    if (!((addr_arr[idx] == addr_arr[g_a]) && (REQ_WE[idx] || REQ_WE[g_a]))) begin
                        gnt_b = 1'b1;
                        g_b   = idx;
                    end
                end
            end
        end
        if (RESET) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

    always_comb begin
        REQ_READY = '0;
        WE_A = 1'b0; RE_A = 1'b0; ADDR_A = '0; DI_A = '0; BE_A = '0;
        WE_B = 1'b0; RE_B = 1'b0; ADDR_B = '0; DI_B = '0; BE_B = '0;
        if (gnt_a) begin
            REQ_READY[g_a] = 1'b1;
            WE_A   = REQ_WE[g_a];
            RE_A   = ~REQ_WE[g_a];
            ADDR_A = addr_arr[g_a];
            DI_A   = data_arr[g_a];
            BE_A   = be_arr[g_a];
        end
        if (gnt_b) begin
            REQ_READY[g_b] = 1'b1;
            WE_B   = REQ_WE[g_b];
            RE_B   = ~REQ_WE[g_b];
            ADDR_B = addr_arr[g_b];
            DI_B   = data_arr[g_b];
            BE_B   = be_arr[g_b];
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        if (gnt_b)      rr_ptr_d = inc_wrap(g_b);
        else if (gnt_a) rr_ptr_d = inc_wrap(g_a);
`ifdef BRAM_ARB_WRITE_ACK_EN
        rsp_v_a_d  = gnt_a;
        rsp_v_b_d  = gnt_b;
`else
        rsp_v_a_d  = gnt_a & ~REQ_WE[g_a];
        rsp_v_b_d  = gnt_b & ~REQ_WE[g_b];
`endif
        rsp_id_a_d = g_a;
        rsp_id_b_d = g_b;
    end

`ifdef BRAM_ARB_WRITE_ACK_EN
    logic rsp_we_a_q, rsp_we_a_d, rsp_we_b_q, rsp_we_b_d;

    always_comb begin
        rsp_we_a_d = REQ_WE[g_a];
        rsp_we_b_d = REQ_WE[g_b];
        rsp_data_a = rsp_we_a_q ? '0 : DO_A;
        rsp_data_b = rsp_we_b_q ? '0 : DO_B;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rsp_we_a_q <= 1'b0;
            rsp_we_b_q <= 1'b0;
        end else begin
            rsp_we_a_q <= rsp_we_a_d;
            rsp_we_b_q <= rsp_we_b_d;
        end
    end
`else
    always_comb begin
        rsp_data_a = DO_A;
        rsp_data_b = DO_B;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_ptr_q   <= '0;
            rsp_v_a_q  <= 1'b0;
            rsp_v_b_q  <= 1'b0;
            rsp_id_a_q <= '0;
            rsp_id_b_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rsp_v_a_q  <= rsp_v_a_d;
            rsp_v_b_q  <= rsp_v_b_d;
            rsp_id_a_q <= rsp_id_a_d;
            rsp_id_b_q <= rsp_id_b_d;
        end
    end

    // Gating on RESET drops a response whose read was granted just before reset.
    always_comb begin
        RESP_VALID = '0;
        RESP_DATA  = '0;
        if (rsp_v_a_q && !RESET) begin
            RESP_VALID[rsp_id_a_q] = 1'b1;
            RESP_DATA[int'(rsp_id_a_q)*DATA_WIDTH +: DATA_WIDTH] = rsp_data_a;
        end
        if (rsp_v_b_q && !RESET) begin
            RESP_VALID[rsp_id_b_q] = 1'b1;
            RESP_DATA[int'(rsp_id_b_q)*DATA_WIDTH +: DATA_WIDTH] = rsp_data_b;
        end
    end

endmodule

// File: tb/tb_bram_dual_port_arbiter.sv
// tb/tb_bram_dual_port_arbiter.sv - self-checking bench for bram_dual_port_arbiter
module tb_bram_dual_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int DEPTH = 1 << AW;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic [N-1:0]    REQ_VALID, REQ_READY, REQ_WE, RESP_VALID;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N*DW-1:0] REQ_DATA, RESP_DATA;
    logic [N*BW-1:0] REQ_BE;
    logic [DW-1:0]   DI_A, DO_A, DI_B, DO_B;
    logic [AW-1:0]   ADDR_A, ADDR_B;
    logic [BW-1:0]   BE_A, BE_B;
    logic            WE_A, RE_A, WE_B, RE_B;

    bram_dual_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_BE(REQ_BE),
        .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA),
        .DI_A(DI_A), .ADDR_A(ADDR_A), .WE_A(WE_A), .RE_A(RE_A), .BE_A(BE_A), .DO_A(DO_A),
        .DI_B(DI_B), .ADDR_B(ADDR_B), .WE_B(WE_B), .RE_B(RE_B), .BE_B(BE_B), .DO_B(DO_B)
    );

    // Requester-side stimulus state
    bit            v [N];
    bit            w [N];
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [BW-1:0] b [N];

    always_comb begin
        REQ_VALID = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_DATA = '0; REQ_BE = '0;
        for (int i = 0; i < N; i++) begin
            REQ_VALID[i]          = v[i];
            REQ_WE[i]             = w[i];
            REQ_ADDR[i*AW +: AW]  = a[i];
            REQ_DATA[i*DW +: DW]  = d[i];
            REQ_BE[i*BW +: BW]    = b[i];
        end
    end

    // Byte-enable BRAM with one cycle read latency
    logic [DW-1:0] ram [DEPTH];
    always @(posedge CLK) begin
        if (WE_A) for (int j = 0; j < BW; j++) if (BE_A[j]) ram[ADDR_A][j*8 +: 8] <= DI_A[j*8 +: 8];
        if (WE_B) for (int j = 0; j < BW; j++) if (BE_B[j]) ram[ADDR_B][j*8 +: 8] <= DI_B[j*8 +: 8];
        if (RE_A) DO_A <= ram[ADDR_A];
        if (RE_B) DO_B <= ram[ADDR_B];
    end

    // Reference model state
    logic [DW-1:0] gm [DEPTH];
    int            ptr;
    bit            pv [N];
    logic [DW-1:0] pd [N];

    int n_chk = 0;
    int n_pass = 0;

    logic [N-1:0]    obs_ready, obs_rv;
    logic [N*DW-1:0] obs_rd;
    logic [AW-1:0]   obs_addr_a;
    logic [3:0]      obs_ctl;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [47:0] exp_port(input int g);
        if (g < 0) return '0;
        return {w[g], ~w[g], a[g], d[g], b[g]};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int j = 0; j < BW; j++) if (be[j]) r[j*8 +: 8] = nw[j*8 +: 8];
        return r;
    endfunction

    task automatic poke(input int addr, input logic [DW-1:0] val);
        ram[addr] <= val;
        gm[addr] = val;
    endtask

    task automatic req(input int i, input bit we, input int addr, input logic [DW-1:0] data,
                       input logic [BW-1:0] be);
        v[i] = 1'b1; w[i] = we; a[i] = AW'(addr); d[i] = data; b[i] = be;
    endtask

    task automatic cycle();
        int q[$];
        int gl[$];
        int ga, gb;
        logic [N-1:0]    er, erv;
        logic [N*DW-1:0] erd;
        @(negedge CLK);
        ga = -1; gb = -1;
        if (!RESET) begin
            for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) q.push_back((ptr + k) % N);
            if (q.size() > 0) ga = q[0];
            if (q.size() > 1 && !(a[q[1]] == a[ga] && (w[q[1]] || w[ga]))) gb = q[1];
        end
        er = '0; erv = '0; erd = '0;
        if (ga >= 0) begin er[ga] = 1'b1; gl.push_back(ga); end
        if (gb >= 0) begin er[gb] = 1'b1; gl.push_back(gb); end
        for (int i = 0; i < N; i++) if (pv[i] && !RESET) begin
            erv[i] = 1'b1;
            erd[i*DW +: DW] = pd[i];
        end
        obs_ready = REQ_READY; obs_rv = RESP_VALID; obs_rd = RESP_DATA;
        obs_addr_a = ADDR_A; obs_ctl = {WE_A, RE_A, WE_B, RE_B};
        chk("ready", REQ_READY, er);
        chk("resp_valid", RESP_VALID, erv);
        chk("resp_data", RESP_DATA, erd);
        chk("port_a", {WE_A, RE_A, ADDR_A, DI_A, BE_A}, exp_port(ga));
        chk("port_b", {WE_B, RE_B, ADDR_B, DI_B, BE_B}, exp_port(gb));
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        if (RESET) ptr = 0;
        else begin
            foreach (gl[k]) begin
`ifdef BRAM_ARB_WRITE_ACK_EN
                pv[gl[k]] = 1'b1;
                pd[gl[k]] = w[gl[k]] ? '0 : gm[a[gl[k]]];
`else
                if (!w[gl[k]]) begin
                    pv[gl[k]] = 1'b1;
                    pd[gl[k]] = gm[a[gl[k]]];
                end
`endif
            end
            foreach (gl[k]) if (w[gl[k]]) gm[a[gl[k]]] = merge(gm[a[gl[k]]], d[gl[k]], b[gl[k]]);
            if (gl.size() > 0) ptr = (gl[gl.size()-1] + 1) % N;
        end
        @(posedge CLK);
        #1;
        foreach (gl[k]) v[gl[k]] = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
    endtask

    logic [N-1:0] t2_exp [3];

    initial begin
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0; b[i] = '0;
            pv[i] = 1'b0; pd[i] = '0;
        end
        ptr = 0;
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        t2_exp[0] = 4'b0011; t2_exp[1] = 4'b1100; t2_exp[2] = 4'b0011;

        cycle();
        do_reset();
        chk("reset_ready", obs_ready, 4'b0000);
        chk("reset_ctl", obs_ctl, 4'b0000);

        poke(5, 32'hCAFE0001);
        req(0, 1'b0, 5, 32'h0, 4'h0);
        cycle();
        chk("t1_ready", obs_ready, 4'b0001);
        chk("t1_addr_a", obs_addr_a, 10'd5);
        chk("t1_ctl", obs_ctl, 4'b0100);
        cycle();
        chk("t1_rv", obs_rv, 4'b0001);
        chk("t1_rd", obs_rd[31:0], 32'hCAFE0001);

        do_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) req(i, 1'b0, 16 + i, 32'h0, 4'h0);
            cycle();
            chk("t2_ready", obs_ready, t2_exp[c]);
        end
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        cycle();
        chk("t2_rv", obs_rv, 4'b0011);

        do_reset();
        req(1, 1'b1, 7, 32'h5A5A1234, 4'hF);
        req(2, 1'b0, 7, 32'h0, 4'h0);
        cycle();
        chk("t3_ready1", obs_ready, 4'b0010);
        chk("t3_b_idle", obs_ctl[1:0], 2'b00);
        cycle();
        chk("t3_ready2", obs_ready, 4'b0100);
        cycle();
        chk("t3_rv", obs_rv, 4'b0100);
        chk("t3_rd", obs_rd[95:64], 32'h5A5A1234);

        do_reset();
        poke(9, 32'h9ABC_DEF0);
        req(0, 1'b0, 9, 32'h0, 4'h0);
        req(3, 1'b0, 9, 32'h0, 4'h0);
        cycle();
        chk("t4_ready", obs_ready, 4'b1001);
        cycle();
        chk("t4_rv", obs_rv, 4'b1001);
        chk("t4_rd", {obs_rd[127:96], obs_rd[31:0]}, {32'h9ABC_DEF0, 32'h9ABC_DEF0});

        do_reset();
        poke(3, 32'h11223344);
        req(0, 1'b1, 3, 32'h0000AB00, 4'b0010);
        cycle();
        chk("t5_wr_ready", obs_ready, 4'b0001);
        req(0, 1'b0, 3, 32'h0, 4'h0);
        cycle();
        chk("t5_rd_ready", obs_ready, 4'b0001);
        cycle();
        chk("t5_rv", obs_rv, 4'b0001);
        chk("t5_rd", obs_rd[31:0], 32'h1122AB44);

        for (int i = 0; i < N; i++) req(i, 1'b0, 32 + i, 32'h0, 4'h0);
        cycle();
        for (int i = 0; i < N; i++) req(i, 1'b0, 32 + i, 32'h0, 4'h0);
        RESET = 1'b1;
        cycle();
        chk("t6_ready", obs_ready, 4'b0000);
        chk("t6_rv", obs_rv, 4'b0000);
        chk("t6_ctl", obs_ctl, 4'b0000);
        RESET = 1'b0;
        cycle();
        chk("t6_first_grant", obs_ready[0], 1'b1);
        chk("t6_addr_a", obs_addr_a, 10'd32);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom_range(3) != 0))
                    req(i, ($urandom_range(2) == 0), $urandom_range(7), $urandom, 4'($urandom_range(15)));
            end
            RESET = ($urandom_range(49) == 0);
            cycle();
        end
        RESET = 1'b0;
        for (int i = 0; i < N; i++) v[i] = 1'b0;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
